// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - GPR write-port arbiter between writeback and a long-latency result queue
module wb_port_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wen,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              lat_valid,
    output logic              lat_ready,
    input  logic [ADDR_W-1:0] lat_rd,
    input  logic [DATA_W-1:0] lat_data,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_MAX);

    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_live;
    logic [DEPTH-1:0]  occ;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W-1:0]  off;
    logic [CNT_W-1:0]  count;
    logic [SC_W-1:0]   starve_cnt;

    logic head_valid;
    logic head_live;
    logic head_dead;
    logic any_live;
    logic pw;
    logic force_wr;
    logic grant_pipe;
    logic grant_q;
    logic pop;
    logic push;
    logic new_live;

    // Slot i is occupied when its distance from the head is below the fill count.
    always_comb begin
        occ = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = PTR_W'(i) - head_ptr;
            occ[i] = {1'b0, off} < count;
        end
    end

    assign head_valid = (count != '0);
    assign head_live  = head_valid & q_live[head_ptr];
    assign head_dead  = head_valid & ~q_live[head_ptr];
    assign any_live   = |(occ & q_live);
    assign pw         = pipe_wen & (pipe_rd != '0);

    assign force_wr   = head_live & (starve_cnt == STARVE_C);
    assign grant_pipe = pw & ~force_wr;
    assign grant_q    = force_wr | (~pw & head_live);
    assign pop        = grant_q | head_dead;

    assign pipe_stall = force_wr;
    assign lat_ready  = (count < DEPTH_C);
    assign busy       = head_valid;
    assign push       = lat_valid & lat_ready & (lat_rd != '0);
    // A result arriving alongside a younger pipe write to the same rd is born dead.
    assign new_live   = ~(grant_pipe & (lat_rd == pipe_rd));

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail_ptr]   <= lat_rd;
            q_data[tail_ptr] <= lat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            q_live     <= '0;
            starve_cnt <= '0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            if (grant_pipe) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_rd[i] == pipe_rd) begin
                        q_live[i] <= 1'b0;
                    end
                end
            end
            if (push) begin
                q_live[tail_ptr] <= new_live;
                tail_ptr         <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (grant_q || !any_live) begin
                starve_cnt <= '0;
            end else if (grant_pipe && starve_cnt != STARVE_C) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            rf_wen <= grant_pipe | grant_q;
            if (grant_q) begin
                rf_waddr <= q_rd[head_ptr];
                rf_wdata <= q_data[head_ptr];
            end else if (grant_pipe) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_rd;
    logic [31:0] lat_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    wb_port_arbiter #(
        .ADDR_W(5), .DATA_W(32), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_rd(lat_rd), .lat_data(lat_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    ent_t mq[$];
    wr_t  exp_q[$];
    int   starve = 0;
    bit   model_valid = 0;
    bit   m_stall;
    bit   m_accept;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = cyc + 1;
        exp_q.push_back(w);
    endtask

    // One clock of stimulus: drive, check combinational outputs, then advance the model.
    task automatic step(input logic r, input logic pwen, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit hl, any_live, pipe_win, wrote_q, pop, m_ready;
        ent_t e;
        @(negedge clk);
        rst = r; pipe_wen = pwen; pipe_rd = prd; pipe_data = pd;
        lat_valid = lv; lat_rd = lrd; lat_data = ld;
        #1;
        m_ready = (mq.size() < DEPTH);
        hl      = (mq.size() != 0) && mq[0].live;
        m_stall = model_valid && hl && (starve == STARVE_MAX);
        if (model_valid) begin
            chk("pipe_stall", 32'(pipe_stall), 32'(m_stall));
            chk("lat_ready", 32'(lat_ready), 32'(m_ready));
            chk("busy", 32'(busy), 32'(mq.size() != 0));
        end
        m_accept = 0;
        if (r) begin
            mq.delete();
            starve = 0;
            model_valid = 1;
        end else begin
            any_live = 0;
            foreach (mq[i]) if (mq[i].live) any_live = 1;
            pipe_win = 0; wrote_q = 0; pop = 0;
            if (m_stall) begin
                push_exp(mq[0].rd, mq[0].data); pop = 1; wrote_q = 1;
            end else if (pwen && prd != 0) begin
                push_exp(prd, pd); pipe_win = 1;
            end else if (hl) begin
                push_exp(mq[0].rd, mq[0].data); pop = 1; wrote_q = 1;
            end
            if (!pop && mq.size() != 0 && !mq[0].live) pop = 1;
            if (pipe_win) foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 0;
            if (pop) void'(mq.pop_front());
            m_accept = lv && m_ready;
            if (m_accept && lrd != 0) begin
                e.rd = lrd; e.data = ld; e.live = !(pipe_win && lrd == prd);
                mq.push_back(e);
            end
            if (wrote_q || !any_live) starve = 0;
            else if (pipe_win && starve < STARVE_MAX) starve++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every register-file write must match the oldest expected write, including its cycle.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rf_wen === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write (cycle %0d)",
                             rf_waddr, rf_wdata, cyc);
                end else begin
                    w = exp_q.pop_front();
                    if (rf_waddr !== w.addr || rf_wdata !== w.data || cyc != w.cyc) begin
                        errors++;
                        $display("FAIL rf_write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                                 rf_waddr, rf_wdata, cyc, w.addr, w.data, w.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    logic        h_pwen, h_lv;
    logic [4:0]  h_prd, h_lrd;
    logic [31:0] h_pd, h_ld;
    bit          p_hold, l_hold, r_now;
    int          pdens, ldens;

    initial begin
        rst = 1; pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
        lat_valid = 0; lat_rd = 0; lat_data = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_rf_wen", 32'(rf_wen), 0);
        chk("reset_rf_waddr", 32'(rf_waddr), 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_pipe_stall", 32'(pipe_stall), 0);
        chk("reset_lat_ready", 32'(lat_ready), 1);
        chk("reset_busy", 32'(busy), 0);

        step(0, 1, 5, 32'hA5, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 7, 32'h11);
        idle(3);

        // One queued entry under continuous writeback: forced write after STARVE_MAX pipe wins.
        step(0, 1, 1, 32'h100, 1, 12, 32'hC0DE);
        for (int i = 0; i < 7; i++) begin
            if (m_stall) i--;
            step(0, 1, 5'(2 + (i % 3)), 32'h200 + 32'(i), 0, 0, 0);
        end
        idle(3);

        // WAW: queued rd=9 killed by younger pipe write, then same-cycle kill of an arriving rd=9.
        step(0, 1, 3, 32'h33, 1, 9, 32'hDEAD);
        step(0, 1, 9, 32'h22, 0, 0, 0);
        idle(3);
        step(0, 1, 9, 32'h44, 1, 9, 32'hBEEF);
        idle(3);

        // Fill the queue with continuous writeback, hold a third offer, then offer rd=0.
        step(0, 1, 4, 32'h1, 1, 10, 32'hA);
        step(0, 1, 4, 32'h2, 1, 11, 32'hB);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 5'(4 + (i % 2)), 32'h10 + 32'(i), !m_accept || i == 0, 13, 32'hC);
        end
        step(0, 0, 0, 0, 1, 0, 32'hFF);
        idle(4);

        // Reset with two entries queued: they must never be written.
        step(0, 1, 6, 32'h66, 1, 14, 32'hE);
        step(0, 1, 6, 32'h67, 1, 15, 32'hF);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_rf_wen", 32'(rf_wen), 0);
        idle(4);

        p_hold = 0; l_hold = 0;
        for (int blk = 0; blk < 6; blk++) begin
            pdens = 20 + blk * 15;
            ldens = 80 - blk * 10;
            for (int i = 0; i < 500; i++) begin
                if (!p_hold) begin
                    h_pwen = ($urandom_range(0, 99) < pdens);
                    h_prd  = 5'($urandom_range(0, 7));
                    h_pd   = $urandom;
                end
                if (!l_hold) begin
                    h_lv  = ($urandom_range(0, 99) < ldens);
                    h_lrd = 5'($urandom_range(0, 7));
                    h_ld  = $urandom;
                end
                r_now = ($urandom_range(0, 399) == 0);
                step(r_now, h_pwen, h_prd, h_pd, h_lv, h_lrd, h_ld);
                p_hold = !r_now && h_pwen && h_prd != 0 && m_stall;
                l_hold = !r_now && h_lv && !m_accept;
            end
        end

        for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1);
        idle(3);
        chk("drain_expected_writes", 32'(exp_q.size()), 0);
        chk("drain_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
